// File: rtl/hack_pkg.sv
// hack_pkg
//
// Shared definitions for the Hack datapath blocks that sit behind the
// 16-bit gate bank (or16/and16/not16).
//
// Contents:
//   WORD_W        - datapath word width (16 bits, bit 15 is the MSB)
//   skid_state_e  - occupancy state of the reg16_skid output stage.
//                   The encoding equals the number of words held, so the
//                   state can drive the occupancy port directly.
//                   2'd3 is never entered; the stage decodes it as EMPTY.
package hack_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage : hack_pkg

// File: rtl/reg16_skid.sv
// reg16_skid
//
// Registered output stage for the 16-bit gate bank. Each gate result is
// taken in with a valid/ready handshake and handed on, registered, to the
// next consumer. A two-entry skid buffer (main + skid registers) sustains
// one word per cycle while in_ready stays a pure flop output, so there is
// no combinational path from out_ready back to in_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_data    in   [WIDTH] word from the upstream gate bank
//   in_valid   in   in_data is valid this cycle
//   in_ready   out  stage can accept a word (flop output)
//   out_data   out  [WIDTH] registered word to the consumer (flop output)
//   out_valid  out  out_data is valid (flop output)
//   out_ready  in   consumer takes out_data this cycle
//   occupancy  out  [2] number of words held: 0, 1 or 2 (flop output)
module reg16_skid
  import hack_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  skid_state_e      state_q;
  skid_state_e      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occ_q;
  logic             in_ready_d;
  logic             out_valid_d;
  logic [1:0]       occ_d;
  logic             acc;
  logic             pop;

  // Handshakes use the registered flags, so a valid or ready seen while the
  // other side is not ready is simply ignored.
  assign acc = in_valid && in_ready_q;
  assign pop = out_valid_q && out_ready;

  // State register together with the registered handshake flags. The flags
  // are computed from the next state so that they line up with the state
  // flop without any decode logic after the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  // Next-state logic. An accept while ONE and popping keeps the stage at one
  // word, which is what gives full throughput without using the skid slot.
  // The unused encoding behaves like EMPTY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (acc) state_d = ONE;
      end
      ONE: begin
        if (acc && !pop)      state_d = FULL;
        else if (!acc && pop) state_d = EMPTY;
      end
      FULL: begin
        if (pop) state_d = ONE;
      end
      default: begin
        state_d = acc ? ONE : EMPTY;
      end
    endcase
  end

  // Output decode for the registered flags, taken from the next state.
  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    occ_d       = state_d;
  end

  // Data registers. The main register always holds the oldest word; the
  // skid register only catches a word that arrives while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state_q)
        ONE: begin
          if (acc && pop)       main_q <= in_data;
          else if (acc && !pop) skid_q <= in_data;
        end
        FULL: begin
          if (pop) main_q <= skid_q;
        end
        default: begin
          if (acc) main_q <= in_data;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule : reg16_skid

// File: tb/tb_reg16_skid.sv
// tb_reg16_skid
//
// Testbench for reg16_skid. Directed scenarios followed by a long random
// run, all compared against a reference model that is simply a queue of
// words in FIFO order bounded at two entries.
module tb_reg16_skid;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  occupancy;

  int unsigned checks;
  int unsigned passes;
  int unsigned fails;

  // Reference model: words held, oldest first.
  logic [15:0] model_q[$];
  bit          after_reset;

  // Throughput bookkeeping for the streaming scenario.
  int unsigned stream_seen;
  bit          stream_mode;

  reg16_skid dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic single comparison with pass/fail bookkeeping.
  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every DUT output against the reference queue.
  task automatic checkOutput(input string tag);
    int n;
    n = model_q.size();
    checkValue({tag, " out_valid"}, {15'd0, out_valid}, {15'd0, (n != 0)});
    checkValue({tag, " in_ready"}, {15'd0, in_ready}, {15'd0, (n < 2)});
    checkValue({tag, " occupancy"}, {14'd0, occupancy}, 16'(n));
    if (n != 0)
      checkValue({tag, " out_data"}, out_data, model_q[0]);
    else if (after_reset)
      checkValue({tag, " out_data_reset"}, out_data, 16'h0000);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input string tag, input logic r, input logic vld,
                               input logic [15:0] d, input logic rdy);
    bit m_acc;
    bit m_pop;
    rst       = r;
    in_valid  = vld;
    in_data   = d;
    out_ready = rdy;
    m_acc = vld && (model_q.size() < 2);
    m_pop = rdy && (model_q.size() > 0);
    if (stream_mode && out_valid && out_ready) begin
      if (out_data === 16'(stream_seen)) stream_seen++;
    end
    @(posedge clk);
    if (r) begin
      model_q.delete();
      after_reset = 1'b1;
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_acc) begin
        model_q.push_back(d);
        after_reset = 1'b0;
      end
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    fails       = 0;
    stream_seen = 0;
    stream_mode = 1'b0;
    after_reset = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 16'h0000;
    out_ready   = 1'b0;

    // Reset, then a single word straight through.
    applyStimulus("reset0", 1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus("reset1", 1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus("single_in", 1'b0, 1'b1, 16'hA5F0, 1'b1);
    checkValue("single_data", out_data, 16'hA5F0);
    applyStimulus("single_out", 1'b0, 1'b0, 16'h0000, 1'b1);

    // Back-pressure fill and ignored pushes while full.
    applyStimulus("fill1", 1'b0, 1'b1, 16'h0001, 1'b0);
    applyStimulus("fill2", 1'b0, 1'b1, 16'h0002, 1'b0);
    checkValue("fill_occ", {14'd0, occupancy}, 16'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("full_ignore", 1'b0, 1'b1, 16'h0003, 1'b0);
      checkValue("full_hold", out_data, 16'h0001);
    end

    // Drain in order.
    applyStimulus("drain1", 1'b0, 1'b0, 16'h0000, 1'b1);
    checkValue("drain1_data", out_data, 16'h0002);
    applyStimulus("drain2", 1'b0, 1'b0, 16'h0000, 1'b1);
    applyStimulus("drain3", 1'b0, 1'b0, 16'h0000, 1'b1);

    // Full-throughput stream of 256 words.
    stream_mode = 1'b1;
    for (int i = 0; i < 256; i++)
      applyStimulus("stream", 1'b0, 1'b1, 16'(i), 1'b1);
    applyStimulus("stream_tail", 1'b0, 1'b0, 16'h0000, 1'b1);
    stream_mode = 1'b0;
    checkValue("stream_count", 16'(stream_seen), 16'd256);

    // Random stalls on both sides.
    for (int i = 0; i < 10000; i++)
      applyStimulus("random", 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));

    // Reset in the middle of a full buffer with both handshakes active.
    applyStimulus("pre_rst_drain1", 1'b0, 1'b0, 16'h0000, 1'b1);
    applyStimulus("pre_rst_drain2", 1'b0, 1'b0, 16'h0000, 1'b1);
    applyStimulus("pre_rst_fill1", 1'b0, 1'b1, 16'h1111, 1'b0);
    applyStimulus("pre_rst_fill2", 1'b0, 1'b1, 16'h2222, 1'b0);
    checkValue("pre_rst_occ", {14'd0, occupancy}, 16'd2);
    applyStimulus("mid_reset", 1'b1, 1'b1, 16'h3333, 1'b1);
    checkValue("mid_reset_occ", {14'd0, occupancy}, 16'd0);
    applyStimulus("post_rst_push", 1'b0, 1'b1, 16'hFFFF, 1'b0);
    checkValue("post_rst_first", out_data, 16'hFFFF);
    applyStimulus("post_rst_pop", 1'b0, 1'b0, 16'h0000, 1'b1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_reg16_skid
